instr_fetch_sequencer: RTL and testbench

- Sequences instruction fetch for pipelined_processor.
- Owns the program counter and drives a 128x12 synchronous-read instruction memory.
- Decodes each fetched word into opcode/dest/source fields with a valid flag.
- Applies branch redirects, back-pressure stalls and a HALT stop, replacing the free-running counter-based fetch.

---
 rtl/proc_pkg.sv | 32 +++
 rtl/instr_field_decode.sv | 15 +
 rtl/instr_fetch_sequencer.sv | 132 +++++++++++++
 tb/tb_instr_fetch_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor types: widths, the halt encoding, instruction
// field positions, the fetch state enum and the decoded-field bundle.
package proc_pkg;

   localparam int ADDR_W  = 7;
   localparam int INSTR_W = 12;

   localparam logic [INSTR_W-1:0] HALT_WORD = 12'hE00;

   localparam int OPC_MSB  = 11;
   localparam int OPC_LSB  = 9;
   localparam int DST_MSB  = 8;
   localparam int DST_LSB  = 6;
   localparam int SRC1_MSB = 5;
   localparam int SRC1_LSB = 3;
   localparam int SRC2_MSB = 2;
   localparam int SRC2_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_HALT
   } fetch_state_t;

   typedef struct packed {
      logic [2:0] opcode;
      logic [2:0] dest;
      logic [2:0] src1;
      logic [2:0] src2;
   } instr_fields_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational split of an instruction word into its fields.
// Ports: instr (raw word in), fields (opcode/dest/src1/src2 out).
module instr_field_decode
   import proc_pkg::*;
(
   input  logic [INSTR_W-1:0] instr,
   output instr_fields_t      fields
);

   assign fields.opcode = instr[OPC_MSB:OPC_LSB];
   assign fields.dest   = instr[DST_MSB:DST_LSB];
   assign fields.src1   = instr[SRC1_MSB:SRC1_LSB];
   assign fields.src2   = instr[SRC2_MSB:SRC2_LSB];

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, drives a sync-read imem,
// registers decoded fields, handles stall, branch redirect and HALT.
// Ports: clk/rst, start; imem_addr/imem_rdata; stall, branch_flag,
// branch_target; instr_valid, opcode, dest_addr, in_addr1, in_addr2,
// pc_out, halted, issue_count.
module instr_fetch_sequencer
   import proc_pkg::*;
#(
   parameter logic [ADDR_W-1:0] START_PC = '0
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               stall,
   input  logic               branch_flag,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic               instr_valid,
   output logic [2:0]         opcode,
   output logic [2:0]         dest_addr,
   output logic [2:0]         in_addr1,
   output logic [2:0]         in_addr2,
   output logic [ADDR_W-1:0]  pc_out,
   output logic               halted,
   output logic [15:0]        issue_count
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] issue_pc_q, issue_pc_d;
   logic              pend_q, pend_d;
   logic              valid_q, valid_d;
   instr_fields_t     flds_q, flds_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              halted_q, halted_d;
   logic [15:0]       cnt_q, cnt_d;
   instr_fields_t     dec;

   instr_field_decode u_dec (
      .instr  (imem_rdata),
      .fields (dec)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= START_PC;
         issue_pc_q <= START_PC;
         pend_q     <= 1'b0;
         valid_q    <= 1'b0;
         flds_q     <= '0;
         pc_q       <= '0;
         halted_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         issue_pc_q <= issue_pc_d;
         pend_q     <= pend_d;
         valid_q    <= valid_d;
         flds_q     <= flds_d;
         pc_q       <= pc_d;
         halted_q   <= halted_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      issue_pc_d = issue_pc_q;
      pend_d     = pend_q;
      valid_d    = valid_q;
      flds_d     = flds_q;
      pc_d       = pc_q;
      halted_d   = halted_q;
      cnt_d      = cnt_q;
      unique case (state_q)
         ST_IDLE, ST_HALT: begin
            if (start) begin
               state_d    = ST_RUN;
               fetch_pc_d = START_PC;
               pend_d     = 1'b0;
               cnt_d      = '0;
               halted_d   = 1'b0;
            end
         end
         ST_RUN: begin
            if (branch_flag) begin
               // words already in flight are dropped
               fetch_pc_d = branch_target;
               pend_d     = 1'b0;
               valid_d    = 1'b0;
            end else if (!stall) begin
               if (pend_q && imem_rdata == HALT_WORD) begin
                  valid_d  = 1'b0;
                  halted_d = 1'b1;
                  state_d  = ST_HALT;
               end else begin
                  issue_pc_d = fetch_pc_q;
                  pend_d     = 1'b1;
                  fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                  valid_d    = pend_q;
                  if (pend_q) begin
                     flds_d = dec;
                     pc_d   = issue_pc_q;
                     if (cnt_q != 16'hFFFF)
                        cnt_d = cnt_q + 16'd1;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // while stalled, re-read the pending word so it is
   // still on imem_rdata when the stall releases
   assign imem_addr = (state_q == ST_RUN && stall && pend_q)
                    ? issue_pc_q : fetch_pc_q;

   assign instr_valid = valid_q;
   assign opcode      = flds_q.opcode;
   assign dest_addr   = flds_q.dest;
   assign in_addr1    = flds_q.src1;
   assign in_addr2    = flds_q.src2;
   assign pc_out      = pc_q;
   assign halted      = halted_q;
   assign issue_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Self-checking bench for instr_fetch_sequencer: directed vector
// table, hand-written halt/reset sequences, random run vs a model.
module tb_instr_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst, start, stall, branch_flag;
   logic [6:0]  branch_target, imem_addr, pc_out;
   logic [11:0] imem_rdata;
   logic        instr_valid, halted;
   logic [2:0]  opcode, dest_addr, in_addr1, in_addr2;
   logic [15:0] issue_count;

   logic [11:0] mem [0:127];

   int checks   = 0;
   int failures = 0;
   bit rnd_on   = 0;

   int          m_mode;
   logic [6:0]  m_fpc, m_ppc, m_pc;
   bit          m_pend, m_valid, m_halted;
   logic [11:0] m_word;
   int          m_cnt;

   typedef struct packed {
      logic        start;
      logic        stall;
      logic        br;
      logic [6:0]  tgt;
      logic        ev;
      logic [6:0]  epc;
      logic [15:0] ecnt;
   } vec_t;

   vec_t tbl[$];

   instr_fetch_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .stall         (stall),
      .branch_flag   (branch_flag),
      .branch_target (branch_target),
      .instr_valid   (instr_valid),
      .opcode        (opcode),
      .dest_addr     (dest_addr),
      .in_addr1      (in_addr1),
      .in_addr2      (in_addr2),
      .pc_out        (pc_out),
      .halted        (halted),
      .issue_count   (issue_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) imem_rdata <= mem[imem_addr];

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [11:0] fields();
      return {opcode, dest_addr, in_addr1, in_addr2};
   endfunction

   // spec-level model: the consumed word is simply mem[pending pc]
   task automatic model_step(input logic r, s, st, b,
                             input logic [6:0] t);
      if (r) begin
         m_mode = 0; m_fpc = 0; m_ppc = 0; m_pend = 0;
         m_valid = 0; m_pc = 0; m_word = 0;
         m_halted = 0; m_cnt = 0;
      end else if (m_mode != 1) begin
         if (s) begin
            m_mode = 1; m_fpc = 0; m_pend = 0;
            m_cnt = 0; m_halted = 0;
         end
      end else if (b) begin
         m_fpc = t; m_pend = 0; m_valid = 0;
      end else if (!st) begin
         if (m_pend && mem[m_ppc] == 12'hE00) begin
            m_valid = 0; m_halted = 1; m_mode = 2;
         end else begin
            m_valid = m_pend;
            if (m_pend) begin
               m_pc   = m_ppc;
               m_word = mem[m_ppc];
               if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end
            m_ppc  = m_fpc;
            m_pend = 1;
            m_fpc  = 7'((m_fpc + 1) % 128);
         end
      end
   endtask

   task automatic cyc(input logic r, s, st, b,
                      input logic [6:0] t);
      logic [6:0] ea;
      rst = r; start = s; stall = st;
      branch_flag = b; branch_target = t;
      #1;
      ea = (m_mode == 1 && st && m_pend) ? m_ppc : m_fpc;
      if (rnd_on) chk("rnd_imem_addr", 32'(imem_addr), 32'(ea));
      @(posedge clk);
      model_step(r, s, st, b, t);
      #1;
      if (rnd_on) begin
         chk("rnd_valid",  32'(instr_valid), 32'(m_valid));
         chk("rnd_pc",     32'(pc_out),      32'(m_pc));
         chk("rnd_fields", 32'(fields()),    32'(m_word));
         chk("rnd_halted", 32'(halted),      32'(m_halted));
         chk("rnd_count",  32'(issue_count), 32'(m_cnt));
      end
   endtask

   task automatic add(input logic s, st, b,
                      input int t, input logic ev,
                      input int pc, input int cnt);
      vec_t v;
      v.start = s; v.stall = st; v.br = b;
      v.tgt = 7'(t); v.ev = ev;
      v.epc = 7'(pc); v.ecnt = 16'(cnt);
      tbl.push_back(v);
   endtask

   initial begin
      int  last;
      bit  got;
      vec_t v;

      for (int i = 0; i < 128; i++) mem[i] = 12'(i + 1);
      m_mode = 0; m_fpc = 0; m_ppc = 0; m_pend = 0;
      m_valid = 0; m_pc = 0; m_word = 0;
      m_halted = 0; m_cnt = 0;

      // start, stream, stall, branch, branch+stall, wrap
      add(1,0,0,  0, 0, 0, 0);
      add(0,0,0,  0, 0, 0, 0);
      for (int i = 0; i < 6; i++) add(0,0,0,0, 1, i, i+1);
      for (int i = 0; i < 3; i++) add(0,1,0,0, 1, 5, 6);
      for (int i = 6; i < 11; i++) add(0,0,0,0, 1, i, i+1);
      add(0,0,1, 40, 0, 0, 11);
      add(0,0,0,  0, 0, 0, 11);
      add(0,0,0,  0, 1, 40, 12);
      add(0,0,0,  0, 1, 41, 13);
      add(0,1,1,  3, 0, 0, 13);
      add(0,0,0,  0, 0, 0, 13);
      add(0,0,0,  0, 1, 3, 14);
      add(0,0,0,  0, 1, 4, 15);
      add(1,0,0,  0, 1, 5, 16);
      add(0,0,1,126, 0, 0, 16);
      add(0,0,0,  0, 0, 0, 16);
      add(0,0,0,  0, 1, 126, 17);
      add(0,0,0,  0, 1, 127, 18);
      add(0,0,0,  0, 1, 0, 19);
      add(0,0,0,  0, 1, 1, 20);

      cyc(1, 0, 0, 0, 0);
      chk("rst_valid",  32'(instr_valid), 0);
      chk("rst_pc",     32'(pc_out),      0);
      chk("rst_fields", 32'(fields()),    0);
      chk("rst_halted", 32'(halted),      0);
      chk("rst_count",  32'(issue_count), 0);
      chk("rst_addr",   32'(imem_addr),   0);

      foreach (tbl[i]) begin
         v = tbl[i];
         cyc(0, v.start, v.stall, v.br, v.tgt);
         chk($sformatf("vec%0d_valid", i),
             32'(instr_valid), 32'(v.ev));
         chk($sformatf("vec%0d_count", i),
             32'(issue_count), 32'(v.ecnt));
         if (v.ev) begin
            chk($sformatf("vec%0d_pc", i),
                32'(pc_out), 32'(v.epc));
            chk($sformatf("vec%0d_fields", i),
                32'(fields()), 32'(mem[v.epc]));
         end
      end

      // halt at word 8
      cyc(1, 0, 0, 0, 0);
      mem[8] = 12'hE00;
      cyc(0, 1, 0, 0, 0);
      last = -1;
      got  = 0;
      for (int i = 0; i < 30 && !got; i++) begin
         cyc(0, 0, 0, 0, 0);
         if (instr_valid) last = int'(pc_out);
         if (halted) got = 1;
      end
      chk("halt_reached", 32'(got),         1);
      chk("halt_last_pc", 32'(last),        7);
      chk("halt_count",   32'(issue_count), 8);
      chk("halt_valid",   32'(instr_valid), 0);
      for (int i = 0; i < 2; i++) begin
         cyc(0, 0, 1, 1, 7'd50);
         chk("halt_hold_addr",  32'(imem_addr),   9);
         chk("halt_hold_valid", 32'(instr_valid), 0);
         chk("halt_hold_count", 32'(issue_count), 8);
      end
      cyc(0, 1, 0, 0, 0);
      chk("restart_halted", 32'(halted),      0);
      chk("restart_count",  32'(issue_count), 0);
      cyc(0, 0, 0, 0, 0);
      chk("restart_v0", 32'(instr_valid), 0);
      cyc(0, 0, 0, 0, 0);
      chk("restart_v1", 32'(instr_valid), 1);
      chk("restart_pc", 32'(pc_out),      0);
      chk("restart_ct", 32'(issue_count), 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      chk("midrst_valid",  32'(instr_valid), 0);
      chk("midrst_pc",     32'(pc_out),      0);
      chk("midrst_fields", 32'(fields()),    0);
      chk("midrst_halted", 32'(halted),      0);
      chk("midrst_count",  32'(issue_count), 0);
      chk("midrst_addr",   32'(imem_addr),   0);

      // random run against the model
      for (int i = 0; i < 128; i++)
         mem[i] = ($urandom_range(0, 39) == 0)
                ? 12'hE00 : 12'($urandom_range(0, 4095));
      cyc(1, 0, 0, 0, 0);
      rnd_on = 1;
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 199) == 0,
             $urandom_range(0, 19) == 0,
             $urandom_range(0, 9) < 3,
             $urandom_range(0, 19) == 0,
             7'($urandom_range(0, 127)));
      rnd_on = 0;

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
